// File: rtl/pwm_pkg.sv
// Shared PWM register map and sequencer state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pwm_pkg;

    // Register addresses on the PWM slave write port
    localparam logic [1:0] PWM_ADDR_DIV    = 2'b00;
    localparam logic [1:0] PWM_ADDR_DUTY_A = 2'b10;
    localparam logic [1:0] PWM_ADDR_DUTY_B = 2'b11;

    // Ramp sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_DIV = 3'd1,
        STEP   = 3'd2,
        WR_A   = 3'd3,
        WR_B   = 3'd4,
        WAIT   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/pwm_ramp_sequencer_if.sv
// Command handshake from config logic plus master write bus towards the PWM slave.
// Latency: n/a (wiring only).
// Backpressure: cfg_valid/cfg_ready handshake; write bus has no wait states.
interface pwm_ramp_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int STEP_W = 16,
    parameter int TICK_W = 16
) ();

    // Command side
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_div;
    logic [DATA_W-1:0] cfg_tgt_a;
    logic [DATA_W-1:0] cfg_tgt_b;
    logic [STEP_W-1:0] cfg_step;
    logic [TICK_W-1:0] cfg_interval;

    // Master write bus
    logic              m_cs;
    logic              m_wr_n;
    logic [1:0]        m_addr;
    logic [DATA_W-1:0] m_wr_data;

    // Sequencer side: accepts commands, drives the write bus
    modport master (
        input  cfg_valid, cfg_div, cfg_tgt_a, cfg_tgt_b, cfg_step, cfg_interval,
        output cfg_ready, m_cs, m_wr_n, m_addr, m_wr_data
    );

    // Peer side: issues commands and observes the write bus
    modport slave (
        output cfg_valid, cfg_div, cfg_tgt_a, cfg_tgt_b, cfg_step, cfg_interval,
        input  cfg_ready, m_cs, m_wr_n, m_addr, m_wr_data
    );

endinterface

// File: rtl/pwm_ramp_step.sv
// Saturating one-step move of a duty value towards its target.
// Latency: combinational.
// Backpressure: none.
module pwm_ramp_step #(
    parameter int DATA_W = 32,
    parameter int STEP_W = 16
) (
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] tgt,
    input  logic [STEP_W-1:0] step,
    output logic [DATA_W-1:0] nxt
);

    logic [DATA_W:0] step_x;
    logic [DATA_W:0] up_sum;
    logic [DATA_W:0] dn_gap;

    // One extra bit keeps cur+step from wrapping; downward moves clamp on the gap to target
    always_comb begin
        step_x = {{(DATA_W + 1 - STEP_W){1'b0}}, step};
        up_sum = {1'b0, cur} + step_x;
        dn_gap = {1'b0, cur} - {1'b0, tgt};
        nxt    = cur;
        if (step == '0) begin
            nxt = tgt;
        end else if (cur < tgt) begin
            nxt = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[DATA_W-1:0];
        end else if (cur > tgt) begin
            nxt = (dn_gap <= step_x) ? tgt : (cur - step_x[DATA_W-1:0]);
        end
    end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Programs PWM divider then ramps duty A/B towards targets by fixed steps at a fixed tick interval.
// Latency: accept c0 -> div write c1 -> duty A write c3 -> duty B write c4; done one cycle after last write.
// Backpressure: cfg_ready only in IDLE; slave has no wait states, every write is a single cycle.
module pwm_ramp_sequencer #(
    parameter int DATA_W = 32,
    parameter int STEP_W = 16,
    parameter int TICK_W = 16
) (
    input  logic                    clk,
    input  logic                    clr_n,
    pwm_ramp_sequencer_if.master    bus,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_W-1:0]       cur_a,
    output logic [DATA_W-1:0]       cur_b
);

    import pwm_pkg::*;

    seq_state_t        state_q;
    seq_state_t        state_d;

    // Latched command
    logic [DATA_W-1:0] tgt_a_q;
    logic [DATA_W-1:0] tgt_b_q;
    logic [STEP_W-1:0] step_q;
    logic [TICK_W-1:0] interval_q;

    // Channel B's next value waits one cycle behind A for its own write slot
    logic [DATA_W-1:0] nxt_b_q;
    logic [TICK_W-1:0] tick_q;

    // Registered bus outputs
    logic              m_cs_q;
    logic              m_wr_n_q;
    logic [1:0]        m_addr_q;
    logic [DATA_W-1:0] m_wr_data_q;
    logic              done_q;

    // Next values for the registered outputs
    logic              cs_d;
    logic              wr_n_d;
    logic [1:0]        addr_d;
    logic [DATA_W-1:0] data_d;
    logic              done_d;
    logic              accept;

    logic [DATA_W-1:0] nxt_a;
    logic [DATA_W-1:0] nxt_b;

    pwm_ramp_step #(.DATA_W(DATA_W), .STEP_W(STEP_W)) u_step_a (
        .cur  (cur_a),
        .tgt  (tgt_a_q),
        .step (step_q),
        .nxt  (nxt_a)
    );

    pwm_ramp_step #(.DATA_W(DATA_W), .STEP_W(STEP_W)) u_step_b (
        .cur  (cur_b),
        .tgt  (tgt_b_q),
        .step (step_q),
        .nxt  (nxt_b)
    );

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.m_cs      = m_cs_q;
    assign bus.m_wr_n    = m_wr_n_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wr_data = m_wr_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next bus cycle; a write is set up one cycle ahead so it appears in its state
    always_comb begin
        state_d = state_q;
        cs_d    = 1'b0;
        wr_n_d  = 1'b1;
        addr_d  = m_addr_q;
        data_d  = m_wr_data_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid && !abort) begin
                    accept  = 1'b1;
                    state_d = WR_DIV;
                    cs_d    = 1'b1;
                    wr_n_d  = 1'b0;
                    addr_d  = PWM_ADDR_DIV;
                    data_d  = bus.cfg_div;
                end
            end
            WR_DIV: begin
                state_d = STEP;
            end
            STEP: begin
                state_d = WR_A;
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = PWM_ADDR_DUTY_A;
                data_d  = nxt_a;
            end
            WR_A: begin
                state_d = WR_B;
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = PWM_ADDR_DUTY_B;
                data_d  = nxt_b_q;
            end
            WR_B: begin
                if ((cur_a == tgt_a_q) && (cur_b == tgt_b_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tick_q <= TICK_W'(1)) begin
                    state_d = STEP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort returns to IDLE; a write already on the bus this cycle still completes
        if (abort) begin
            state_d = IDLE;
            cs_d    = 1'b0;
            wr_n_d  = 1'b1;
            addr_d  = m_addr_q;
            data_d  = m_wr_data_q;
            done_d  = 1'b0;
        end
    end

    // Bus and done output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_cs_q      <= 1'b0;
            m_wr_n_q    <= 1'b1;
            m_addr_q    <= 2'b00;
            m_wr_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            m_cs_q      <= cs_d;
            m_wr_n_q    <= wr_n_d;
            m_addr_q    <= addr_d;
            m_wr_data_q <= data_d;
            done_q      <= done_d;
        end
    end

    // Command capture on accept
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tgt_a_q    <= '0;
            tgt_b_q    <= '0;
            step_q     <= '0;
            interval_q <= '0;
        end else if (accept) begin
            tgt_a_q    <= bus.cfg_tgt_a;
            tgt_b_q    <= bus.cfg_tgt_b;
            step_q     <= bus.cfg_step;
            interval_q <= bus.cfg_interval;
        end
    end

    // Track values as their writes go onto the bus; aborted steps leave them untouched
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cur_a   <= '0;
            cur_b   <= '0;
            nxt_b_q <= '0;
        end else begin
            if (state_q == STEP && state_d == WR_A) begin
                cur_a   <= nxt_a;
                nxt_b_q <= nxt_b;
            end
            if (state_q == WR_A && state_d == WR_B) begin
                cur_b <= nxt_b_q;
            end
        end
    end

    // Inter-step interval counter; an interval of zero behaves as one
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tick_q <= '0;
        end else if (state_q == WR_B && state_d == WAIT) begin
            tick_q <= (interval_q == '0) ? TICK_W'(1) : interval_q;
        end else if (state_q == WAIT && state_d == WAIT) begin
            tick_q <= tick_q - TICK_W'(1);
        end else begin
            tick_q <= '0;
        end
    end

endmodule
